// File: rtl/tag_issuer_if.sv
// Request/release/status bundle for the tag issuer.
// The master side drives requests and releases; the slave side returns slot state.
interface tag_issuer_if #(
  parameter int TAG_W = 16,
  parameter int LANES = 8
);
  logic                   req_a;
  logic [2:0]             lane_a;
  logic                   req_b;
  logic [2:0]             lane_b;
  logic                   rel_vld;
  logic                   rel_port;
  logic [2:0]             rel_lane;
  logic [LANES-1:0]       vlda;
  logic [LANES-1:0]       vldb;
  logic [LANES*TAG_W-1:0] taga;
  logic [LANES*TAG_W-1:0] tagb;
  logic                   gnt_a;
  logic                   gnt_b;
  logic [4:0]             live_cnt;

  modport master (
    output req_a, lane_a, req_b, lane_b, rel_vld, rel_port, rel_lane,
    input  vlda, vldb, taga, tagb, gnt_a, gnt_b, live_cnt
  );

  modport slave (
    input  req_a, lane_a, req_b, lane_b, rel_vld, rel_port, rel_lane,
    output vlda, vldb, taga, tagb, gnt_a, gnt_b, live_cnt
  );
endinterface

// File: rtl/tag_issuer.sv
// Issues tags to two ports x LANES slots so that no two live tags are ever equal.
// Port A has priority; a candidate that clashes with a live tag is skipped, not retried.
module tag_issuer #(
  parameter int TAG_W = 16,
  parameter int LANES = 8
) (
  input  logic        clk,
  input  logic        rst,
  tag_issuer_if.slave bus
);
  logic [LANES-1:0] r_vlda;
  logic [LANES-1:0] r_vldb;
  logic [TAG_W-1:0] r_taga [LANES];
  logic [TAG_W-1:0] r_tagb [LANES];
  logic [TAG_W-1:0] r_next_tag;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic [4:0]       r_live_cnt;

  logic [TAG_W-1:0] w_cand0;
  logic [TAG_W-1:0] w_cand1;
  logic [TAG_W-1:0] w_cand_b;
  logic [TAG_W-1:0] w_next_tag;
  logic             w_hit0;
  logic             w_hit1;
  logic             w_hit_b;
  logic             w_use_a;
  logic             w_use_b;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic [1:0]       w_adv;
  logic [LANES-1:0] w_vlda_nxt;
  logic [LANES-1:0] w_vldb_nxt;
  logic [4:0]       w_live_nxt;

  assign w_cand0 = r_next_tag;
  assign w_cand1 = r_next_tag + {{(TAG_W-1){1'b0}}, 1'b1};

  // Both candidates are compared against every live slot, both ports.
  always_comb begin
    w_hit0 = 1'b0;
    w_hit1 = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (r_vlda[i] && (r_taga[i] == w_cand0)) w_hit0 = 1'b1;
      if (r_vldb[i] && (r_tagb[i] == w_cand0)) w_hit0 = 1'b1;
      if (r_vlda[i] && (r_taga[i] == w_cand1)) w_hit1 = 1'b1;
      if (r_vldb[i] && (r_tagb[i] == w_cand1)) w_hit1 = 1'b1;
    end
  end

  assign w_use_a  = bus.req_a && !r_vlda[bus.lane_a];
  assign w_gnt_a  = w_use_a && !w_hit0;
  assign w_cand_b = w_gnt_a ? w_cand1 : w_cand0;
  assign w_hit_b  = w_gnt_a ? w_hit1 : w_hit0;
  assign w_use_b  = bus.req_b && !r_vldb[bus.lane_b];
  assign w_gnt_b  = w_use_b && !w_hit_b;

  // A request on a free lane consumes its candidate even when the tag clashes.
  always_comb begin
    w_adv = 2'd0;
    if (w_use_a) begin
      w_adv = (w_use_b && w_gnt_a) ? 2'd2 : 2'd1;
    end else if (w_use_b) begin
      w_adv = 2'd1;
    end
  end

  assign w_next_tag = r_next_tag + {{(TAG_W-2){1'b0}}, w_adv};

  // A grant needs a clear slot and a release only touches a set one, so they never collide.
  always_comb begin
    w_vlda_nxt = r_vlda;
    w_vldb_nxt = r_vldb;
    if (bus.rel_vld) begin
      if (bus.rel_port) w_vldb_nxt[bus.rel_lane] = 1'b0;
      else              w_vlda_nxt[bus.rel_lane] = 1'b0;
    end
    if (w_gnt_a) w_vlda_nxt[bus.lane_a] = 1'b1;
    if (w_gnt_b) w_vldb_nxt[bus.lane_b] = 1'b1;
  end

  always_comb begin
    w_live_nxt = 5'd0;
    for (int i = 0; i < LANES; i++) begin
      w_live_nxt = w_live_nxt + {4'd0, w_vlda_nxt[i]} + {4'd0, w_vldb_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vlda     <= '0;
      r_vldb     <= '0;
      r_next_tag <= '0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_live_cnt <= 5'd0;
      for (int i = 0; i < LANES; i++) begin
        r_taga[i] <= '0;
        r_tagb[i] <= '0;
      end
    end else begin
      r_vlda     <= w_vlda_nxt;
      r_vldb     <= w_vldb_nxt;
      r_next_tag <= w_next_tag;
      r_gnt_a    <= w_gnt_a;
      r_gnt_b    <= w_gnt_b;
      r_live_cnt <= w_live_nxt;
      if (w_gnt_a) r_taga[bus.lane_a] <= w_cand0;
      if (w_gnt_b) r_tagb[bus.lane_b] <= w_cand_b;
    end
  end

  assign bus.vlda     = r_vlda;
  assign bus.vldb     = r_vldb;
  assign bus.gnt_a    = r_gnt_a;
  assign bus.gnt_b    = r_gnt_b;
  assign bus.live_cnt = r_live_cnt;

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign bus.taga[g*TAG_W +: TAG_W] = r_taga[g];
    assign bus.tagb[g*TAG_W +: TAG_W] = r_tagb[g];
  end
endmodule

// File: tb/tb_tag_issuer.sv
// Self-checking bench for tag_issuer: directed scenarios plus random traffic
// compared every cycle against a slot-level reference model.
module tb_tag_issuer;
  localparam int TAG_W = 16;
  localparam int LANES = 8;
  localparam int unsigned MOD = 1 << TAG_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tag_issuer_if #(.TAG_W(TAG_W), .LANES(LANES)) bus ();
  tag_issuer #(.TAG_W(TAG_W), .LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // reference model: slot occupancy and tags per port, plus the tag counter
  bit          m_va [LANES];
  bit          m_vb [LANES];
  int unsigned m_ta [LANES];
  int unsigned m_tb [LANES];
  int unsigned m_next;
  bit          m_ga, m_gb;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_live(input int unsigned t);
    for (int i = 0; i < LANES; i++) begin
      if (m_va[i] && m_ta[i] == t) return 1'b1;
      if (m_vb[i] && m_tb[i] == t) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_va[i] = 1'b0; m_vb[i] = 1'b0; m_ta[i] = 0; m_tb[i] = 0;
    end
    m_next = 0; m_ga = 1'b0; m_gb = 1'b0;
  endtask

  // One clock of the rules: A tries next_tag; B tries whichever candidate is left.
  task automatic model_update();
    int unsigned c0, cb;
    bit a_use, a_g, b_use, b_g;
    int adv;
    c0    = m_next;
    a_use = bus.req_a && !m_va[bus.lane_a];
    a_g   = a_use && !is_live(c0);
    cb    = a_g ? (c0 + 1) % MOD : c0;
    b_use = bus.req_b && !m_vb[bus.lane_b];
    b_g   = b_use && !is_live(cb);
    if (a_use) adv = (b_use && a_g) ? 2 : 1;
    else       adv = b_use ? 1 : 0;
    if (bus.rel_vld) begin
      if (bus.rel_port) m_vb[bus.rel_lane] = 1'b0;
      else              m_va[bus.rel_lane] = 1'b0;
    end
    if (a_g) begin m_va[bus.lane_a] = 1'b1; m_ta[bus.lane_a] = c0; end
    if (b_g) begin m_vb[bus.lane_b] = 1'b1; m_tb[bus.lane_b] = cb; end
    m_ga   = a_g;
    m_gb   = b_g;
    m_next = (m_next + adv) % MOD;
  endtask

  function automatic logic [127:0] exp_tags(input bit port_b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*TAG_W +: TAG_W] = port_b ? m_tb[i][TAG_W-1:0] : m_ta[i][TAG_W-1:0];
    return r;
  endfunction

  function automatic logic [127:0] exp_vld(input bit port_b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i] = port_b ? m_vb[i] : m_va[i];
    return r;
  endfunction

  // Compare process: DUT state against the model, plus the uniqueness invariant.
  always @(negedge clk) begin
    if (chk_en) begin
      int dup, pop;
      logic [TAG_W-1:0] t [2*LANES];
      bit v [2*LANES];
      chk("vlda", 128'(bus.vlda), exp_vld(1'b0));
      chk("vldb", 128'(bus.vldb), exp_vld(1'b1));
      chk("taga", 128'(bus.taga), exp_tags(1'b0));
      chk("tagb", 128'(bus.tagb), exp_tags(1'b1));
      chk("gnt_a", 128'(bus.gnt_a), 128'(m_ga));
      chk("gnt_b", 128'(bus.gnt_b), 128'(m_gb));
      pop = 0;
      for (int i = 0; i < LANES; i++) pop += int'(m_va[i]) + int'(m_vb[i]);
      chk("live_cnt", 128'(bus.live_cnt), 128'(pop));
      for (int i = 0; i < LANES; i++) begin
        v[i] = bus.vlda[i];       t[i] = bus.taga[i*TAG_W +: TAG_W];
        v[LANES+i] = bus.vldb[i]; t[LANES+i] = bus.tagb[i*TAG_W +: TAG_W];
      end
      dup = 0;
      for (int i = 0; i < 2*LANES; i++)
        for (int j = i + 1; j < 2*LANES; j++)
          if (v[i] && v[j] && t[i] == t[j]) dup++;
      chk("unique", 128'(dup), 128'(0));
    end
  end

  task automatic idle_inputs();
    bus.req_a = 1'b0; bus.lane_a = 3'd0; bus.req_b = 1'b0; bus.lane_b = 3'd0;
    bus.rel_vld = 1'b0; bus.rel_port = 1'b0; bus.rel_lane = 3'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] ta(input int l);
    return bus.taga[l*TAG_W +: TAG_W];
  endfunction

  function automatic logic [15:0] tb(input int l);
    return bus.tagb[l*TAG_W +: TAG_W];
  endfunction

  initial begin
    int k;
    do_reset();
    chk_en = 1'b1;
    chk("rst_vlda", 128'(bus.vlda), 128'(0));
    chk("rst_live", 128'(bus.live_cnt), 128'(0));
    chk("rst_taga", 128'(bus.taga), 128'(0));

    // double grant on lane 2 straight out of reset
    bus.req_a = 1'b1; bus.lane_a = 3'd2; bus.req_b = 1'b1; bus.lane_b = 3'd2;
    step(); idle_inputs();
    chk("d36_gnt_a", 128'(bus.gnt_a), 128'(1));
    chk("d36_gnt_b", 128'(bus.gnt_b), 128'(1));
    chk("d36_taga2", 128'(ta(2)), 128'(16'h0000));
    chk("d36_tagb2", 128'(tb(2)), 128'(16'h0001));
    chk("d36_live", 128'(bus.live_cnt), 128'(2));

    // occupied lane: second request on A3 is refused and consumes nothing
    bus.req_a = 1'b1; bus.lane_a = 3'd3; step();
    chk("d37_taga3", 128'(ta(3)), 128'(16'h0002));
    step(); idle_inputs();
    chk("d37_gnt_a", 128'(bus.gnt_a), 128'(0));
    bus.req_a = 1'b1; bus.lane_a = 3'd6; step(); idle_inputs();
    chk("d37_taga6", 128'(ta(6)), 128'(16'h0003));

    // release and request of A5 in the same cycle
    bus.req_a = 1'b1; bus.lane_a = 3'd5; step();
    bus.rel_vld = 1'b1; bus.rel_port = 1'b0; bus.rel_lane = 3'd5;
    step(); idle_inputs();
    chk("d38_vlda5", 128'(bus.vlda[5]), 128'(0));
    chk("d38_gnt_a", 128'(bus.gnt_a), 128'(0));
    bus.req_a = 1'b1; bus.lane_a = 3'd5; step(); idle_inputs();
    chk("d38_retry_gnt", 128'(bus.gnt_a), 128'(1));
    chk("d38_taga5", 128'(ta(5)), 128'(16'h0005));
    chk("d38_live", 128'(bus.live_cnt), 128'(5));

    // wrap: tag 0 held on B0 while the counter is walked up to 0xFFFF
    do_reset();
    bus.req_b = 1'b1; bus.lane_b = 3'd0; step(); idle_inputs();
    chk("w_tagb0", 128'(tb(0)), 128'(16'h0000));
    k = 0;
    while (m_next != 32'hFFFF && k < 70000) begin
      bus.req_a = 1'b1; bus.lane_a = 3'(2 + (k % 2));
      bus.rel_vld = 1'b1; bus.rel_port = 1'b0; bus.rel_lane = 3'(3 - (k % 2));
      step();
      k++;
    end
    idle_inputs();
    chk("w_walk_bound", 128'(m_next), 128'(32'hFFFF));
    bus.req_a = 1'b1; bus.lane_a = 3'd1; step();
    chk("w_taga1", 128'(ta(1)), 128'(16'hFFFF));
    bus.lane_a = 3'd4; step();
    chk("w_skip_gnt", 128'(bus.gnt_a), 128'(0));
    step(); idle_inputs();
    chk("w_retry_gnt", 128'(bus.gnt_a), 128'(1));
    chk("w_taga4", 128'(ta(4)), 128'(16'h0001));

    // random traffic
    for (int c = 0; c < 12000; c++) begin
      bus.req_a = 1'($urandom_range(0, 1)); bus.lane_a = 3'($urandom_range(0, 7));
      bus.req_b = 1'($urandom_range(0, 1)); bus.lane_b = 3'($urandom_range(0, 7));
      bus.rel_vld = 1'($urandom_range(0, 1)); bus.rel_port = 1'($urandom_range(0, 1));
      bus.rel_lane = 3'($urandom_range(0, 7));
      step();
    end
    idle_inputs();

    // async reset with 10 live slots
    for (int i = 0; i < 2*LANES; i++) begin
      bus.rel_vld = 1'b1; bus.rel_port = 1'(i / LANES); bus.rel_lane = 3'(i % LANES);
      step();
    end
    idle_inputs();
    chk("ar_drained", 128'(bus.live_cnt), 128'(0));
    for (int i = 0; i < 5; i++) begin
      bus.req_a = 1'b1; bus.lane_a = 3'(i); bus.req_b = 1'b1; bus.lane_b = 3'(i);
      step();
    end
    idle_inputs();
    chk("ar_live10", 128'(bus.live_cnt), 128'(10));
    #2 rst = 1'b1;
    #1;
    chk("ar_vlda", 128'(bus.vlda), 128'(0));
    chk("ar_vldb", 128'(bus.vldb), 128'(0));
    chk("ar_taga", 128'(bus.taga), 128'(0));
    chk("ar_tagb", 128'(bus.tagb), 128'(0));
    chk("ar_gnt", 128'({bus.gnt_a, bus.gnt_b}), 128'(0));
    chk("ar_live", 128'(bus.live_cnt), 128'(0));
    model_reset();
    #2 rst = 1'b0;
    bus.req_a = 1'b1; bus.lane_a = 3'd7; step(); idle_inputs();
    chk("ar_first_gnt", 128'(bus.gnt_a), 128'(1));
    chk("ar_first_tag", 128'(ta(7)), 128'(16'h0000));

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
